ldpc_cyc_shift_pipe: RTL and testbench

- Pipelined, parametrised cyclic lane rotator for the LDPC decoder message network.
- Rotates one block of D lanes by a per-beat circulant shift, in either direction:
  - forward: variable-to-check;
  - inverse: check-to-variable, undoing the forward rotation.
- Null-block marker substitutes a fill pattern.
- Valid/ready handshake with full backpressure; carries a sideband tag so the scheduler can match results to issued blocks.

---
 rtl/ldpc_cyc_shift_pipe.sv | 145 ++++++++++++++
 tb/tb_ldpc_cyc_shift_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_cyc_shift_pipe.sv
// rtl/ldpc_cyc_shift_pipe.sv - pipelined cyclic lane rotator for the LDPC message network
module ldpc_cyc_shift_pipe #(
    parameter int                LANE_W    = 11,
    parameter int                D         = 5,
    parameter int                MTX_W     = 8,
    parameter int                TAG_W     = 4,
    parameter logic [LANE_W-1:0] NULL_FILL = {1'b0, {(LANE_W-1){1'b1}}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANE_W*D-1:0]   in_data,
    input  logic [MTX_W-1:0]      in_shift,
    input  logic                  in_dir,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_W*D-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_null,
    output logic                  out_err
);
    localparam int                  S        = $clog2(D);
    localparam int                  DW       = LANE_W * D;
    localparam logic [MTX_W-1:0]    D_LIM    = MTX_W'(D);
    localparam logic [DW-1:0]       NULL_BLK = {D{NULL_FILL}};

    logic         en;
    logic         in_null;
    logic         in_err;
    logic [S-1:0] in_s;

    // Flags are only meaningful for real beats, so bubbles never carry them
    assign in_null = in_valid & (&in_shift);
    assign in_err  = in_valid & ~(&in_shift) & (in_shift >= D_LIM);
    assign in_s    = (in_null | in_err) ? '0 : in_shift[S-1:0];

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int AMT = (2 ** k) % D;

        logic             src_v;
        logic [DW-1:0]    src_dat;
        logic [S-1:0]     src_s;
        logic             src_dir;
        logic             src_null;
        logic             src_err;
        logic [TAG_W-1:0] src_tag;
        logic [DW-1:0]    rot;
        logic [DW-1:0]    nxt;

        logic             r_v;
        logic [DW-1:0]    r_dat;
        logic [TAG_W-1:0] r_tag;
        logic             r_null;
        logic             r_err;

        if (k == 0) begin : g_src
            assign src_v    = in_valid;
            assign src_dat  = in_data;
            assign src_s    = in_s;
            assign src_dir  = in_dir;
            assign src_null = in_null;
            assign src_err  = in_err;
            assign src_tag  = in_tag;
        end else begin : g_src
            assign src_v    = g_stage[k-1].r_v;
            assign src_dat  = g_stage[k-1].r_dat;
            assign src_s    = g_stage[k-1].g_ctl.r_s;
            assign src_dir  = g_stage[k-1].g_ctl.r_dir;
            assign src_null = g_stage[k-1].r_null;
            assign src_err  = g_stage[k-1].r_err;
            assign src_tag  = g_stage[k-1].r_tag;
        end

        // Indices wrap modulo D, not modulo 2^S, so partial circulants rotate correctly
        always_comb begin
            rot = src_dat;
            if (src_s[k]) begin
                for (int i = 0; i < D; i++) begin
                    if (src_dir) begin
                        rot[i*LANE_W +: LANE_W] = src_dat[((i + D - AMT) % D)*LANE_W +: LANE_W];
                    end else begin
                        rot[i*LANE_W +: LANE_W] = src_dat[((i + AMT) % D)*LANE_W +: LANE_W];
                    end
                end
            end
        end

        if (k == S - 1) begin : g_fill
            always_comb begin
                nxt = rot;
                if (src_null) begin
                    nxt = NULL_BLK;
                end else if (src_err) begin
                    nxt = '0;
                end
            end
        end else begin : g_fill
            assign nxt = rot;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v    <= 1'b0;
                r_dat  <= '0;
                r_tag  <= '0;
                r_null <= 1'b0;
                r_err  <= 1'b0;
            end else if (en) begin
                r_v    <= src_v;
                r_dat  <= nxt;
                r_tag  <= src_tag;
                r_null <= src_null;
                r_err  <= src_err;
            end
        end

        // Shift and direction are consumed by later stages only
        if (k < S - 1) begin : g_ctl
            logic [S-1:0] r_s;
            logic         r_dir;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s   <= '0;
                    r_dir <= 1'b0;
                end else if (en) begin
                    r_s   <= src_s;
                    r_dir <= src_dir;
                end
            end
        end
    end

    assign out_valid = g_stage[S-1].r_v;
    assign out_data  = g_stage[S-1].r_dat;
    assign out_tag   = g_stage[S-1].r_tag;
    assign out_null  = g_stage[S-1].r_null;
    assign out_err   = g_stage[S-1].r_err;

endmodule

// File: tb/tb_ldpc_cyc_shift_pipe.sv
// tb/tb_ldpc_cyc_shift_pipe.sv - scoreboard bench for ldpc_cyc_shift_pipe
module tb_ldpc_cyc_shift_pipe;
    localparam int LW = 4;
    localparam int DL = 5;
    localparam int DW = LW * DL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [7:0]    in_shift;
    logic          in_dir;
    logic [3:0]    in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_tag;
    logic          out_null;
    logic          out_err;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    tag;
        logic          nul;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   lat_chk = 0;
    bit   rnd_rdy = 0;

    ldpc_cyc_shift_pipe #(
        .LANE_W(LW), .D(DL), .MTX_W(8), .TAG_W(4), .NULL_FILL(4'h7)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_dir(in_dir), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_null(out_null), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [7:0] sh,
                                            input logic dir, output logic nul, output logic err);
        logic [DW-1:0] r;
        int s;
        nul = (sh == 8'hFF);
        err = !nul && (sh >= 8'd5);
        r = '0;
        if (nul) begin
            for (int i = 0; i < DL; i++) r[i*LW +: LW] = 4'h7;
        end else if (!err) begin
            s = int'(sh);
            for (int i = 0; i < DL; i++) begin
                if (!dir) r[i*LW +: LW] = d[((i + s) % DL)*LW +: LW];
                else      r[i*LW +: LW] = d[((i - s + DL) % DL)*LW +: LW];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_exp(input logic [DW-1:0] d, input logic [7:0] sh, input logic dir,
                            input logic [3:0] tag, input logic [DW-1:0] ed,
                            input logic en_, input logic ee);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_shift = sh; in_dir = dir; in_tag = tag;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 200) break;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stuck low for tag %0h", tag);
            in_valid = 1'b0;
        end else begin
            e.data = ed; e.tag = tag; e.nul = en_; e.err = ee; e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic send_mod(input logic [DW-1:0] d, input logic [7:0] sh, input logic dir,
                            input logic [3:0] tag);
        logic [DW-1:0] ed;
        logic n, e;
        ed = model(d, sh, dir, n, e);
        send_exp(d, sh, dir, tag, ed, n, e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every presented beat is compared against the scoreboard front
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) continue;
            n_cmp++;
            if (in_ready !== (out_ready || !out_valid)) begin
                n_bad++;
                $display("FAIL in_ready: got %b expected %b", in_ready, out_ready || !out_valid);
            end
            if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_beat: data %h tag %h, expected no output", out_data, out_tag);
                end else begin
                    if (out_data !== q[0].data || out_tag !== q[0].tag ||
                        out_null !== q[0].nul || out_err !== q[0].err) begin
                        n_bad++;
                        $display("FAIL beat: got data %h tag %h null %b err %b expected data %h tag %h null %b err %b",
                                 out_data, out_tag, out_null, out_err,
                                 q[0].data, q[0].tag, q[0].nul, q[0].err);
                    end
                    if (out_ready) begin
                        if (lat_chk) check("latency", 32'(cyc - q[0].cyc), 32'd3);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [7:0] sh;
        int r;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0;
        in_tag = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_null", 32'(out_null), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        lat_chk = 1'b1;
        send_exp(20'h54321, 8'd2, 1'b0, 4'd3, 20'h21543, 1'b0, 1'b0);
        send_exp(20'h54321, 8'd2, 1'b1, 4'd4, 20'h32154, 1'b0, 1'b0);
        send_exp(20'h21543, 8'd2, 1'b1, 4'd5, 20'h54321, 1'b0, 1'b0);
        send_exp(20'h54321, 8'hFF, 1'b0, 4'd6, 20'h77777, 1'b1, 1'b0);
        send_exp(20'h54321, 8'd7, 1'b0, 4'd7, 20'h00000, 1'b0, 1'b1);
        send_exp(20'h54321, 8'd0, 1'b1, 4'd8, 20'h54321, 1'b0, 1'b0);
        send_exp(20'h54321, 8'd5, 1'b1, 4'd9, 20'h00000, 1'b0, 1'b1);
        for (int s = 0; s < 5; s++) send_mod(20'h54321, 8'(s), 1'b0, 4'(s));
        idle();
        drain();

        // Full pipeline held under backpressure
        lat_chk = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_mod(20'($urandom()), 8'(i + 1), 1'(i % 2), 4'(10 + i));
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        send_mod(20'($urandom()), 8'd4, 1'b1, 4'd13);
        send_mod(20'($urandom()), 8'd3, 1'b0, 4'd14);
        idle();
        drain();

        // Reset with beats in flight
        send_mod(20'h13579, 8'd1, 1'b0, 4'd1);
        send_mod(20'h2468A, 8'd3, 1'b1, 4'd2);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        lat_chk = 1'b1;
        send_mod(20'h54321, 8'd1, 1'b1, 4'd15);
        idle();
        drain();

        // Randomised traffic with random backpressure
        lat_chk = 1'b0;
        rnd_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            d = 20'($urandom());
            r = $urandom_range(0, 9);
            if (r < 6)      sh = 8'($urandom_range(0, 4));
            else if (r < 8) sh = 8'($urandom_range(5, 254));
            else            sh = 8'hFF;
            send_mod(d, sh, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        idle();
        rnd_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
